// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch sequencing logic.
package cpu_pkg;

  localparam int unsigned CPU_ADDR_W  = 32;
  localparam int unsigned CPU_MDU_LAT = 34;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_HOLD_MDU = 2'd1,
    S_HOLD_EXT = 2'd2,
    S_PEND     = 2'd3
  } fetch_state_t;

  // Counter width able to hold values 0..lat
  function automatic int unsigned hold_cnt_width(input int unsigned lat);
    return $clog2(lat + 1);
  endfunction

endpackage

// File: rtl/fetch_hold_cnt.sv
// Down-counter that times multi-cycle MDU holds.
// A load sets MDU_LAT-1 so that the load cycle plus the countdown
// together give exactly MDU_LAT hold cycles.
module fetch_hold_cnt
  import cpu_pkg::*;
#(
  parameter int unsigned MDU_LAT = CPU_MDU_LAT,
  parameter int unsigned CNT_W   = hold_cnt_width(MDU_LAT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  output logic [CNT_W-1:0] count,
  output logic             nonzero
);

  // Reset/clear beats load; otherwise count down to zero and stay there
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(MDU_LAT - 1);
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign nonzero = (count != '0);

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencing controller: merges hazards, MDU holds, external
// stalls, branches and traps into one hold-or-jump command per cycle.
// Hold and jump are never issued together; a branch arriving during a hold
// is parked and replayed on the first hold-free cycle.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W  = CPU_ADDR_W,
  parameter int unsigned MDU_LAT = CPU_MDU_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_use,
  input  logic              mdu_start,
  input  logic              ext_stall,
  input  logic              br_req,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              trap_req,
  input  logic [ADDR_W-1:0] trap_target,
  output logic              hold_flag,
  output logic              jump_flag,
  output logic [ADDR_W-1:0] jump_addr,
  output logic              flush_id,
  output logic              flush_ex,
  output logic              busy
);

  localparam int unsigned CNT_W = hold_cnt_width(MDU_LAT);

  fetch_state_t      state;
  logic              pend_vld;
  logic [ADDR_W-1:0] pend_addr;
  logic [CNT_W-1:0]  cnt;
  logic              cnt_nz;

  logic              hold_cond;
  logic              defer_br;
  logic              release_pend;
  logic              pend_next;
  logic              cnt_next_nz;

  fetch_hold_cnt #(
    .MDU_LAT (MDU_LAT),
    .CNT_W   (CNT_W)
  ) u_hold_cnt (
    .clk     (clk),
    .rst     (rst),
    .clr     (trap_req),
    .load    (mdu_start),
    .count   (cnt),
    .nonzero (cnt_nz)
  );

  // Per-cycle command arbitration: trap > branch > pending > holds > load_use
  always_comb begin
    hold_flag    = 1'b0;
    jump_flag    = 1'b0;
    jump_addr    = '0;
    flush_id     = 1'b0;
    flush_ex     = 1'b0;
    hold_cond    = ext_stall || cnt_nz || mdu_start;
    defer_br     = br_req && !pend_vld && hold_cond;
    release_pend = pend_vld && !hold_cond;
    pend_next    = pend_vld ? hold_cond : defer_br;
    if (trap_req) begin
      cnt_next_nz = 1'b0;
    end else if (mdu_start) begin
      cnt_next_nz = (MDU_LAT > 1);
    end else begin
      cnt_next_nz = (cnt > CNT_W'(1));
    end

    if (rst) begin
      hold_flag = 1'b0;
    end else if (trap_req) begin
      jump_flag = 1'b1;
      jump_addr = trap_target;
      flush_id  = 1'b1;
      flush_ex  = 1'b1;
    end else if (br_req && !pend_vld && !hold_cond) begin
      jump_flag = 1'b1;
      jump_addr = br_target;
      flush_id  = 1'b1;
    end else if (defer_br) begin
      hold_flag = 1'b1;
      flush_id  = 1'b1;
    end else if (release_pend) begin
      // ID holds a wrong-path copy refetched during the hold; kill it too
      jump_flag = 1'b1;
      jump_addr = pend_addr;
      flush_id  = 1'b1;
    end else if (hold_cond || load_use) begin
      hold_flag = 1'b1;
    end

    busy = !rst && (state != S_RUN);
  end

  // State and parked-redirect registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      pend_vld  <= 1'b0;
      pend_addr <= '0;
    end else if (trap_req) begin
      state     <= S_RUN;
      pend_vld  <= 1'b0;
    end else begin
      pend_vld <= pend_next;
      if (defer_br) begin
        pend_addr <= br_target;
      end
      if (pend_next) begin
        state <= S_PEND;
      end else if (ext_stall) begin
        state <= S_HOLD_EXT;
      end else if (cnt_next_nz) begin
        state <= S_HOLD_MDU;
      end else begin
        state <= S_RUN;
      end
    end
  end

  a_hold_jump_excl : assert property (@(posedge clk) disable iff (rst)
    !(hold_flag && jump_flag));

  a_mdu_reload : assert property (@(posedge clk) disable iff (rst)
    !(mdu_start && !trap_req && cnt_nz));

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus a random run, all checked
// every cycle against a queue-based model of the redirect rules.
module tb_fetch_ctrl;

  localparam int unsigned AW  = 32;
  localparam int unsigned LAT = 4;

  logic          clk = 1'b0;
  logic          rst, load_use, mdu_start, ext_stall, br_req, trap_req;
  logic [AW-1:0] br_target, trap_target;
  logic          hold_flag, jump_flag, flush_id, flush_ex, busy;
  logic [AW-1:0] jump_addr;

  int total = 0;
  int bad   = 0;

  // model state
  int            m_mdu_left = 0;
  logic [AW-1:0] m_pend_q[$];
  bit            m_busy = 1'b0;
  int            m_jumps = 0;
  int            d_jumps = 0;

  // last sampled values, DUT (s_) and model (e_)
  logic          s_hold, s_jump, s_fid, s_fex, s_busy;
  logic [AW-1:0] s_addr;
  logic          e_hold, e_jump, e_fid, e_fex, e_busy;
  logic [AW-1:0] e_addr;

  always #5 clk = ~clk;

  fetch_ctrl #(
    .ADDR_W  (AW),
    .MDU_LAT (LAT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .load_use    (load_use),
    .mdu_start   (mdu_start),
    .ext_stall   (ext_stall),
    .br_req      (br_req),
    .br_target   (br_target),
    .trap_req    (trap_req),
    .trap_target (trap_target),
    .hold_flag   (hold_flag),
    .jump_flag   (jump_flag),
    .jump_addr   (jump_addr),
    .flush_id    (flush_id),
    .flush_ex    (flush_ex),
    .busy        (busy)
  );

  task automatic chk(input string name, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  // One clock: sample at negedge, compare against model, advance model
  task automatic cycle();
    bit stall_now;
    @(negedge clk);
    s_hold = hold_flag; s_jump = jump_flag; s_addr = jump_addr;
    s_fid  = flush_id;  s_fex  = flush_ex;  s_busy = busy;

    e_hold = 0; e_jump = 0; e_addr = '0; e_fid = 0; e_fex = 0;
    e_busy = rst ? 1'b0 : m_busy;
    stall_now = ext_stall || (m_mdu_left > 0) || mdu_start;
    if (!rst) begin
      if (trap_req) begin
        e_jump = 1; e_addr = trap_target; e_fid = 1; e_fex = 1;
      end else if (br_req && m_pend_q.size() == 0) begin
        if (stall_now) begin e_hold = 1; e_fid = 1; end
        else begin e_jump = 1; e_addr = br_target; e_fid = 1; end
      end else if (m_pend_q.size() != 0 && !stall_now) begin
        e_jump = 1; e_addr = m_pend_q[0]; e_fid = 1;
      end else begin
        e_hold = stall_now || load_use;
      end
    end

    chk("hold_flag", AW'(s_hold), AW'(e_hold));
    chk("jump_flag", AW'(s_jump), AW'(e_jump));
    chk("flush_id",  AW'(s_fid),  AW'(e_fid));
    chk("flush_ex",  AW'(s_fex),  AW'(e_fex));
    chk("busy",      AW'(s_busy), AW'(e_busy));
    chk("hold_jump_excl", AW'(s_hold & s_jump), '0);
    if (e_jump) chk("jump_addr", s_addr, e_addr);
    if (s_jump) d_jumps++;
    if (e_jump) m_jumps++;

    if (rst || trap_req) begin
      m_mdu_left = 0;
      m_pend_q.delete();
      m_busy = 0;
    end else begin
      if (br_req && m_pend_q.size() == 0 && stall_now) m_pend_q.push_back(br_target);
      else if (m_pend_q.size() != 0 && !stall_now) void'(m_pend_q.pop_front());
      if (mdu_start) m_mdu_left = LAT - 1;
      else if (m_mdu_left > 0) m_mdu_left--;
      m_busy = (m_pend_q.size() != 0) || ext_stall || (m_mdu_left > 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit r, input bit lu, input bit ms, input bit es,
                       input bit br, input logic [AW-1:0] bt,
                       input bit tr, input logic [AW-1:0] tt);
    rst = r; load_use = lu; mdu_start = ms; ext_stall = es;
    br_req = br; br_target = bt; trap_req = tr; trap_target = tt;
    cycle();
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, '0, 0, '0);
  endtask

  initial begin
    int stall_run;
    // 1: reset with every input high
    drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    drive(1, 1, 1, 1, 1, 32'hFFFF_FFFF, 1, 32'hFFFF_FFFF);
    chk("rst_hold", AW'(s_hold), '0);
    chk("rst_jump", AW'(s_jump), '0);
    chk("rst_addr", s_addr, '0);
    chk("rst_busy", AW'(s_busy), '0);
    idle();
    chk("idle_hold", AW'(s_hold), '0);
    chk("idle_busy", AW'(s_busy), '0);

    // 2: lone branch redirects in the same cycle
    drive(0, 0, 0, 0, 1, 32'h1000_0040, 0, '0);
    chk("br_jump", AW'(s_jump), 1);
    chk("br_addr", s_addr, 32'h1000_0040);
    chk("br_fid",  AW'(s_fid), 1);
    chk("br_hold", AW'(s_hold), '0);

    // 3: MDU hold of LAT cycles with a branch deferred to its release
    drive(0, 0, 1, 0, 0, '0, 0, '0);
    chk("mdu_t0_hold", AW'(s_hold), 1);
    drive(0, 0, 0, 0, 1, 32'h4000_0100, 0, '0);
    chk("mdu_t1_hold", AW'(s_hold), 1);
    chk("mdu_t1_jump", AW'(s_jump), '0);
    idle();
    chk("mdu_t2_hold", AW'(s_hold), 1);
    idle();
    chk("mdu_t3_hold", AW'(s_hold), 1);
    idle();
    chk("mdu_t4_hold", AW'(s_hold), '0);
    chk("mdu_t4_jump", AW'(s_jump), 1);
    chk("mdu_t4_addr", s_addr, 32'h4000_0100);
    idle();

    // 4: trap during an external stall discards the parked branch
    drive(0, 0, 0, 1, 0, '0, 0, '0);
    drive(0, 0, 0, 1, 1, 32'h2000_0008, 0, '0);
    chk("ext_defer_hold", AW'(s_hold), 1);
    drive(0, 0, 0, 1, 0, '0, 1, 32'h4000_0000);
    chk("trap_jump", AW'(s_jump), 1);
    chk("trap_addr", s_addr, 32'h4000_0000);
    chk("trap_hold", AW'(s_hold), '0);
    chk("trap_fex",  AW'(s_fex), 1);
    idle();
    chk("post_trap_jump", AW'(s_jump), '0);
    chk("post_trap_busy", AW'(s_busy), '0);

    // 5: load_use loses to a branch; alone it holds one cycle
    drive(0, 1, 0, 0, 1, 32'h0000_0200, 0, '0);
    chk("lu_br_jump", AW'(s_jump), 1);
    chk("lu_br_hold", AW'(s_hold), '0);
    drive(0, 1, 0, 0, 0, '0, 0, '0);
    chk("lu_hold", AW'(s_hold), 1);
    idle();
    chk("lu_release", AW'(s_hold), '0);

    // 6: reset while a branch is parked behind a running MDU count
    drive(0, 0, 1, 0, 0, '0, 0, '0);
    drive(0, 0, 0, 0, 1, 32'h5555_0000, 0, '0);
    drive(1, 0, 0, 0, 0, '0, 0, '0);
    idle();
    chk("rst_pend_busy", AW'(s_busy), '0);
    for (int i = 0; i < 6; i++) begin
      idle();
      chk("rst_pend_nojump", AW'(s_jump), '0);
    end

    // random run
    stall_run = 0;
    for (int i = 0; i < 10000; i++) begin
      if (stall_run > 0) stall_run--;
      else if ($urandom_range(0, 11) == 0) stall_run = $urandom_range(1, 6);
      rst         = ($urandom_range(0, 199) == 0);
      trap_req    = ($urandom_range(0, 39) == 0);
      br_req      = ($urandom_range(0, 7) == 0);
      load_use    = ($urandom_range(0, 9) == 0);
      mdu_start   = (m_mdu_left == 0) && ($urandom_range(0, 24) == 0);
      ext_stall   = (stall_run > 0);
      br_target   = $urandom;
      trap_target = $urandom;
      cycle();
    end
    idle();
    idle();
    chk("redirect_count", AW'(d_jumps), AW'(m_jumps));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
